// File: rtl/alu_share_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_share_ctrl_if : requester, ALU and response bundle for alu_share_ctrl |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface alu_share_ctrl_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [32*N-1:0]  req_a;
  logic [32*N-1:0]  req_b;
  logic [3*N-1:0]   req_sel;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_c;
  logic [31:0]      alu_d;
  logic [2:0]       alu_sel;
  logic [32:0]      alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [32:0]      rsp_data;
  logic             rsp_err;
  logic [15:0]      op_count;
  logic [7:0]       err_count;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, alu_out, rsp_ready,
    output req_ready, alu_a, alu_b, alu_c, alu_d, alu_sel,
           rsp_valid, rsp_id, rsp_data, rsp_err, op_count, err_count
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, alu_out, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_c, alu_d, alu_sel,
           rsp_valid, rsp_id, rsp_data, rsp_err, op_count, err_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_share_ctrl : round-robin sharing of one registered ALU among N users  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_share_ctrl #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  alu_share_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_gidx;
  logic           w_found;
  logic [N-1:0]   w_grant;
  logic [31:0]    w_a;
  logic [31:0]    w_b;
  logic [2:0]     w_sel;
  logic           w_legal;
  logic           w_hs;

  logic [31:0]    r_alu_a;
  logic [31:0]    r_alu_b;
  logic [2:0]     r_alu_sel;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [32:0]    r_rsp_data;
  logic           r_rsp_err;
  logic [15:0]    r_op_count;
  logic [7:0]     r_err_count;

  // First asserted valid strictly after the last winner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int j = 1; j <= N; j++) begin
      if (!w_found && bus.req_valid[IDW'((int'(r_ptr) + j) % N)]) begin
        w_found = 1'b1;
        w_gidx  = IDW'((int'(r_ptr) + j) % N);
      end
    end
    w_grant = w_found ? ({{(N-1){1'b0}}, 1'b1} << w_gidx) : '0;
  end

  assign w_a     = bus.req_a[w_gidx*32 +: 32];
  assign w_b     = bus.req_b[w_gidx*32 +: 32];
  assign w_sel   = bus.req_sel[w_gidx*3 +: 3];
  assign w_legal = (w_sel != 3'd7);
  assign w_hs    = (r_state == S_IDLE) && w_found;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = w_legal ? S_ISSUE : S_RESP;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = S_RESP;
      S_RESP:  if (r_rsp_valid && bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= IDW'(N - 1);
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_op_count  <= '0;
      r_err_count <= '0;
    end else begin
      if (w_hs) begin
        r_ptr    <= w_gidx;
        r_rsp_id <= w_gidx;
        if (w_legal) begin
          r_alu_a   <= w_a;
          r_alu_b   <= w_b;
          r_alu_sel <= w_sel;
        end else begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
      end
      if (r_state == S_WAIT) begin
        r_rsp_data  <= bus.alu_out;
        r_rsp_err   <= 1'b0;
        r_rsp_valid <= 1'b1;
        if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
      end
      // A rejected request enters RESP with valid still low; raise it one cycle later.
      if (r_state == S_RESP) begin
        if (!r_rsp_valid)        r_rsp_valid <= 1'b1;
        else if (bus.rsp_ready)  r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = (rst && r_state == S_IDLE) ? w_grant : '0;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_c     = '0;
  assign bus.alu_d     = '0;
  assign bus.alu_sel   = r_alu_sel;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.op_count  = r_op_count;
  assign bus.err_count = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_share_ctrl : randomized bench for alu_share_ctrl with ALU stand-in |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_alu_share_ctrl;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.N(N), .IDW(IDW)) bus ();
  alu_share_ctrl #(.N(N), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode table of the shared ALU.
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] sel);
    case (sel)
      3'd0:    return {1'b0, a};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a} + {1'b0, b};
      3'd3:    return {1'b0, a} << b[4:0];
      3'd4:    return {1'b0, a | b};
      3'd5:    return {1'b0, a & b};
      3'd6:    return {1'b0, a ^ b};
      default: return 33'd0;
    endcase
  endfunction

  // Synchronous-reset, one-cycle registered ALU.
  always @(posedge clk) begin
    if (!rst) bus.alu_out <= '0;
    else      bus.alu_out <= alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);
  end

  function automatic int arb(input logic [N-1:0] v, input int ptr);
    for (int j = 1; j <= N; j++)
      if (v[(ptr + j) % N]) return (ptr + j) % N;
    return -1;
  endfunction

  // Reference model: one outstanding transaction described by its handshake cycle.
  int          cyc = 0;
  bit          m_busy;
  bit          m_legal;
  int          m_hs;
  int          m_ptr;
  int          m_ops;
  int          m_errs;
  int          m_id;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_sel;
  logic [32:0] m_data;
  bit          m_err;

  task automatic model_step();
    int          g;
    bit          erv;
    logic [N-1:0] er;
    logic [31:0] a, b;
    logic [2:0]  s;
    if (!rst) begin
      m_busy = 0; m_ptr = N - 1; m_ops = 0; m_errs = 0;
      m_a = '0; m_b = '0; m_sel = '0;
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_sel", bus.alu_sel, 0);
      chk("rst_op_count", bus.op_count, 0);
      chk("rst_err_count", bus.err_count, 0);
    end else begin
      g   = m_busy ? -1 : arb(bus.req_valid, m_ptr);
      er  = (g >= 0) ? (N'(1) << g) : '0;
      erv = m_busy && (cyc >= m_hs + (m_legal ? 3 : 2));
      chk("req_ready", bus.req_ready, er);
      chk("rsp_valid", bus.rsp_valid, erv);
      chk("alu_a", bus.alu_a, m_a);
      chk("alu_b", bus.alu_b, m_b);
      chk("alu_sel", bus.alu_sel, m_sel);
      chk("alu_cd", {bus.alu_c, bus.alu_d}, 0);
      chk("op_count", bus.op_count, m_ops);
      chk("err_count", bus.err_count, m_errs);
      if (erv) begin
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_data", bus.rsp_data, m_data);
        chk("rsp_err", bus.rsp_err, m_err);
      end
      if (erv && bus.rsp_ready) begin
        m_busy = 0;
      end else if (g >= 0) begin
        a = bus.req_a[32*g +: 32];
        b = bus.req_b[32*g +: 32];
        s = bus.req_sel[3*g +: 3];
        m_ptr = g; m_id = g; m_busy = 1; m_hs = cyc; m_legal = (s != 3'd7);
        if (m_legal) begin
          m_a = a; m_b = b; m_sel = s; m_data = alu_f(a, b, s); m_err = 0;
        end else begin
          m_data = '0; m_err = 1;
          if (m_errs < 255) m_errs++;
        end
      end
      if (m_busy && m_legal && cyc == m_hs + 2 && m_ops < 65535) m_ops++;
    end
    cyc++;
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] s);
    bus.req_valid[IDW'(i)] = v;
    bus.req_a[32*i +: 32]  = a;
    bus.req_b[32*i +: 32]  = b;
    bus.req_sel[3*i +: 3]  = s;
  endtask

  task automatic wait_grant(input int i, input string name);
    int n = 0;
    do begin @(negedge clk); #2; n++; end while (!bus.req_ready[IDW'(i)] && n < 20);
    if (!bus.req_ready[IDW'(i)]) chk({name, "_grant_timeout"}, 0, 1);
  endtask

  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] s, input logic [32:0] exp_d, input bit exp_e,
                       input int exp_lat, input string name);
    int lat = 0;
    @(posedge clk); #1;
    set_req(i, 1'b1, a, b, s);
    wait_grant(i, name);
    @(posedge clk); #1;
    bus.req_valid[IDW'(i)] = 1'b0;
    do begin @(negedge clk); #2; lat++; end while (!bus.rsp_valid && lat < 20);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_id"}, bus.rsp_id, i);
    chk({name, "_data"}, bus.rsp_data, exp_d);
    chk({name, "_err"}, bus.rsp_err, exp_e);
    @(posedge clk); #1; bus.rsp_ready = 1'b1;
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [N-1:0]  hs;
    logic [IDW-1:0] ids [5];
    logic [32:0]   dat [5];
    int            tc  [5];
    int            k, n;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_sel = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    do_op(0, 32'd3, 32'd4, 3'd2, 33'd7, 1'b0, 3, "add");
    chk("op_count_first", bus.op_count, 1);
    do_op(1, 32'd5, 32'd7, 3'd1, 33'h1_FFFF_FFFE, 1'b0, 3, "sub");
    do_op(2, 32'h0001_0000, 32'd16, 3'd3, 33'h1_0000_0000, 1'b0, 3, "shl");
    do_op(3, 32'hDEAD_BEEF, 32'd1, 3'd7, 33'd0, 1'b1, 2, "illegal");
    chk("illegal_err_count", bus.err_count, 1);
    chk("illegal_op_count", bus.op_count, 3);
    chk("illegal_alu_a_kept", bus.alu_a, 32'h0001_0000);
    chk("illegal_alu_sel_kept", bus.alu_sel, 3);

    // All requesters continuously valid.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h1234_5678 + 32'(i) * 32'h100, 32'hFFFF, 3'd5);
    bus.rsp_ready = 1'b1;
    k = 0; n = 0;
    while (k < 5 && n < 60) begin
      @(negedge clk); #2; n++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        ids[k] = bus.rsp_id; dat[k] = bus.rsp_data; tc[k] = n; k++;
      end
    end
    @(posedge clk); #1; bus.req_valid = '0;
    chk("rr_count", k, 5);
    for (int j = 0; j < 5; j++) begin
      chk("rr_id", ids[j], j % 4);
      chk("rr_data", dat[j], 33'h5678 + 33'(j % 4) * 33'h100);
    end
    chk("rr_throughput", tc[4] - tc[0], 16);
    repeat (10) @(posedge clk);
    #1 bus.rsp_ready = 1'b0;

    // Response held under backpressure.
    set_req(1, 1'b1, 32'd10, 32'd20, 3'd2);
    wait_grant(1, "bp");
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    set_req(2, 1'b1, 32'hAB, 32'd0, 3'd0);
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!bus.rsp_valid && n < 20);
    for (int j = 0; j < 10; j++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_id", bus.rsp_id, 1);
      chk("bp_data", bus.rsp_data, 30);
      chk("bp_ready", bus.req_ready, 0);
      @(negedge clk); #2;
    end
    @(posedge clk); #1; bus.rsp_ready = 1'b1;
    @(posedge clk); #1; bus.rsp_ready = 1'b0;
    @(negedge clk); #2;
    chk("bp_next_grant", bus.req_ready, 4'b0100);
    @(posedge clk); #1; bus.req_valid[2] = 1'b0; bus.rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 bus.rsp_ready = 1'b0;

    // Randomized traffic, requests held until granted or voluntarily dropped.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #2;
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !bus.req_valid[i]) begin
          set_req(i, ($urandom_range(0, 2) == 0), $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  3'($urandom_range(0, 7)));
        end else if ($urandom_range(0, 9) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid = '0; bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);

    // Flood of rejected opcodes drives err_count into saturation.
    #1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'd1, 32'd1, 3'd7);
    repeat (1000) @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (6) @(posedge clk);
    chk("err_count_saturated", bus.err_count, 8'hFF);

    // Asynchronous reset while an operation sits in WAIT.
    #1 bus.rsp_ready = 1'b0;
    set_req(1, 1'b1, 32'd1, 32'd1, 3'd2);
    wait_grant(1, "rstwait");
    @(posedge clk); #1; bus.req_valid[1] = 1'b0;
    @(posedge clk); #2; rst = 1'b0;
    #1;
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_alu_a", bus.alu_a, 0);
    chk("arst_op_count", bus.op_count, 0);
    chk("arst_err_count", bus.err_count, 0);
    set_req(0, 1'b1, 32'd9, 32'd1, 3'd2);
    set_req(3, 1'b1, 32'd8, 32'd1, 3'd2);
    #1 chk("arst_req_ready", bus.req_ready, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #2;
    chk("arst_first_grant", bus.req_ready, 4'b0001);
    @(posedge clk); #1; bus.req_valid = '0; bus.rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("arst_op_after", bus.op_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
